// File: rtl/cpu_mc.sv
// Parametrised multi-cycle core for the four-form 32-bit instruction set.
// Requests and retire are registered, with a ready/valid handshake to a word-addressed memory.
module cpu_mc #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 30,
  parameter logic [AW-1:0] RESET_PC = '0,
  localparam int unsigned RW = (DW > 32) ? DW : 32
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [RW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          retire,
  output logic [AW-1:0] dbg_pc
);

  localparam int unsigned SW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, MEM} state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [31:0]   ir, ir_n;
  logic [DW-1:0] regs [16];

  logic          rf_we;
  logic [3:0]    rf_wa;
  logic [DW-1:0] rf_wd;
  logic          retire_n, re_n, we_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n;

  // Instruction fields
  logic [1:0]        form;
  logic [3:0]        aluop, rd, ra, rb;
  logic signed [15:0] imm_s;
  logic [DW-1:0]     zx, sx, ra_val, rb_val, rd_val;
  logic [AW-1:0]     sx_aw, pc_inc, target, ea;
  logic [DW-1:0]     link_val;

  assign form   = ir[31:30];
  assign aluop  = ir[27:24];
  assign rd     = ir[23:20];
  assign ra     = ir[19:16];
  assign rb     = ir[15:12];
  assign imm_s  = ir[15:0];
  assign zx     = DW'(ir[15:0]);
  assign sx     = DW'(imm_s);
  assign sx_aw  = AW'(imm_s);
  assign ra_val = regs[ra];
  assign rb_val = regs[rb];
  assign rd_val = regs[rd];

  assign pc_inc   = pc + AW'(1);
  assign target   = pc_inc + sx_aw;
  assign ea       = AW'(ra_val + sx);
  assign link_val = DW'(pc_inc);

  // ALU for reg-reg and reg-imm forms
  logic [DW-1:0] alu_b, alu_y;
  always_comb begin
    alu_b = (form == 2'd0) ? rb_val : zx;
    alu_y = '0;
    case (aluop)
      4'd0:    alu_y = ra_val + alu_b;
      4'd1:    alu_y = ra_val - alu_b;
      4'd2:    alu_y = ra_val & alu_b;
      4'd3:    alu_y = ra_val | alu_b;
      4'd4:    alu_y = ra_val ^ alu_b;
      4'd5:    alu_y = ra_val << alu_b[SW-1:0];
      4'd6:    alu_y = ra_val >> alu_b[SW-1:0];
      4'd7:    alu_y = DW'($signed(ra_val) >>> alu_b[SW-1:0]);
      4'd8:    alu_y = DW'($signed(ra_val) < $signed(alu_b));
      4'd9:    alu_y = DW'(ra_val < alu_b);
      4'd10:   alu_y = alu_b;
      default: alu_y = '0;
    endcase
  end

  logic taken;
  always_comb begin
    case (ir[29:28])
      2'b01:   taken = (ra_val == '0);
      2'b10:   taken = (ra_val != '0);
      default: taken = 1'b1;
    endcase
  end

  // Next-state, register-file write and registered-output decode
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    rf_we    = 1'b0;
    rf_wa    = rd;
    rf_wd    = alu_y;
    retire_n = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (mem_ready) begin
          ir_n    = mem_rdata[31:0];
          state_n = EXEC;
        end
      end
      EXEC: begin
        case (form)
          2'd0, 2'd1: begin
            rf_we    = 1'b1;
            pc_n     = pc_inc;
            retire_n = 1'b1;
            state_n  = FETCH;
          end
          2'd2: state_n = MEM;
          default: begin
            rf_we    = (ir[29:28] == 2'b11);
            rf_wd    = link_val;
            pc_n     = taken ? target : pc_inc;
            retire_n = 1'b1;
            state_n  = FETCH;
          end
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          rf_we    = ~ir[29];
          rf_wd    = mem_rdata[DW-1:0];
          pc_n     = pc_inc;
          retire_n = 1'b1;
          state_n  = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase

    // Registers are untouched while in MEM, so ea and rd_val stay stable during waits
    re_n   = (state_n == FETCH) || ((state_n == MEM) && !ir_n[29]);
    we_n   = (state_n == MEM) && ir_n[29];
    addr_n = '0;
    if (state_n == FETCH)    addr_n = pc_n;
    else if (state_n == MEM) addr_n = ea;
    wdata_n = we_n ? rd_val : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      mem_re    <= re_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      retire    <= retire_n;
      if (rf_we && (rf_wa != 4'd0)) regs[rf_wa] <= rf_wd;
    end
  end

  assign dbg_pc = pc;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: table of ALU vectors plus hand-written handshake,
// branch, wrap-around and reset sequences against a wait-state memory model.
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re, mem_we, mem_ready, retire;
  logic [29:0] mem_addr, dbg_pc;
  logic [31:0] mem_wdata, mem_rdata;

  cpu_mc dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .retire(retire), .dbg_pc(dbg_pc)
  );

  always #5 clk = ~clk;

  // Memory model: data window 0x20..0x7F inserts data_wait wait states
  logic [31:0] mem [256];
  int          data_wait = 0;
  int          wcnt = 0;
  logic        data_addr;
  assign data_addr = (mem_addr >= 30'h20) && (mem_addr < 30'h80);
  assign mem_ready = data_addr ? (wcnt >= data_wait) : 1'b1;
  assign mem_rdata = mem[mem_addr[7:0]];

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } st_t;
  st_t st_q[$];
  int  ret_cnt = 0;
  int  both_cnt = 0;

  always @(posedge clk) begin
    if (mem_ready || !(mem_re || mem_we)) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (!rst && mem_we && mem_ready) st_q.push_back({mem_addr, mem_wdata});
    if (retire) ret_cnt <= ret_cnt + 1;
    if (mem_re && mem_we) both_cnt <= both_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000FFFF;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, n, r0, base;
    logic [4:0]  pat;

    vecs[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[1]  = '{4'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE};
    vecs[2]  = '{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
    vecs[3]  = '{4'd3,  32'hF0000000, 32'h0000000F, 32'hF000000F};
    vecs[4]  = '{4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
    vecs[5]  = '{4'd5,  32'h00000001, 32'h00000024, 32'h00000010};
    vecs[6]  = '{4'd6,  32'h80000000, 32'h00000004, 32'h08000000};
    vecs[7]  = '{4'd7,  32'h80000000, 32'h00000004, 32'hF8000000};
    vecs[8]  = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[9]  = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[10] = '{4'd10, 32'h00000007, 32'h12345678, 32'h12345678};
    vecs[11] = '{4'd12, 32'h00000005, 32'h00000006, 32'h00000000};

    // Main program: ALU, store/load with waits, r0 write, BL, self-loop
    rst = 1'b1;
    data_wait = 3;
    clear_mem();
    mem[0]  = 32'h40100005;
    mem[1]  = 32'h00211000;
    mem[2]  = 32'hA0200020;
    mem[3]  = 32'h80300020;
    mem[4]  = 32'hA0300021;
    mem[5]  = 32'h40000007;
    mem[6]  = 32'hA0000022;
    mem[7]  = 32'hF0F00002;
    mem[8]  = 32'hA000002F;
    mem[9]  = 32'hA000002F;
    mem[10] = 32'hA0F00024;
    mem[11] = 32'hE001FFFF;
    mem[32] = 32'd10;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ctl", 64'({mem_re, mem_we, retire}), 64'(0));
      check("rst_bus", 64'({mem_addr, mem_wdata}), 64'(0));
      check("rst_pc", 64'(dbg_pc), 64'(0));
    end
    rst = 1'b0;
    check("idle_re", 64'(mem_re), 64'(0));
    tick();
    check("fetch0_re", 64'(mem_re), 64'(1));
    check("fetch0_addr", 64'(mem_addr), 64'(0));
    check("fetch0_pc", 64'(dbg_pc), 64'(0));

    pat = 5'b10100;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("retire_seq", 64'(retire), 64'(pat[i]));
    end

    k = 0;
    while (!mem_we && k < 10) begin tick(); k++; end
    check("st_start", 64'(mem_we), 64'(1));
    r0 = ret_cnt;
    n = 0;
    while (mem_we && n < 10) begin
      check("st_addr", 64'(mem_addr), 64'(32'h20));
      check("st_wdata", 64'(mem_wdata), 64'(10));
      n++;
      tick();
    end
    check("st_hold_cycles", 64'(n), 64'(4));
    check("st_no_early_retire", 64'(ret_cnt - r0), 64'(0));
    check("st_retire", 64'(retire), 64'(1));

    data_wait = 2;
    k = 0;
    while (!(mem_re && mem_addr == 30'h20) && k < 10) begin tick(); k++; end
    n = 0;
    while (mem_re && mem_addr == 30'h20 && n < 10) begin n++; tick(); end
    check("ld_hold_cycles", 64'(n), 64'(3));

    repeat (40) tick();
    check("store_count", 64'(st_q.size()), 64'(4));
    if (st_q.size() >= 4) begin
      check("store0", 64'(st_q[0]), 64'({30'h20, 32'd10}));
      check("store_load_r3", 64'(st_q[1]), 64'({30'h21, 32'd10}));
      check("store_r0", 64'(st_q[2]), 64'({30'h22, 32'd0}));
      check("store_link_r15", 64'(st_q[3]), 64'({30'h24, 32'd8}));
    end
    check("self_loop_pc", 64'(dbg_pc), 64'(11));

    // Branch on ra!=0 with r1=0 falls through
    rst = 1'b1;
    data_wait = 0;
    tick(); tick();
    clear_mem();
    mem[0] = 32'hE001FFFF;
    mem[1] = 32'hC000FFFF;
    rst = 1'b0;
    repeat (20) tick();
    check("bnz_not_taken_pc", 64'(dbg_pc), 64'(1));

    // ALU table: load a,b; op r3; store r3 to 0x40
    data_wait = 1;
    for (int i = 0; i < 12; i++) begin
      rst = 1'b1;
      tick(); tick();
      clear_mem();
      mem[0]  = 32'h80100030;
      mem[1]  = 32'h80200031;
      mem[2]  = {2'b00, 2'b00, vecs[i].op, 4'd3, 4'd1, 4'd2, 12'd0};
      mem[3]  = 32'hA0300040;
      mem[48] = vecs[i].a;
      mem[49] = vecs[i].b;
      base = st_q.size();
      rst = 1'b0;
      repeat (40) tick();
      check("alu_store_count", 64'(st_q.size() - base), 64'(1));
      if (st_q.size() > base)
        check("alu_result", 64'(st_q[base]), 64'({30'h40, vecs[i].y}));
    end

    // pc wrap: branch back to 2^AW-1, then ALU op there falls through to 0
    rst = 1'b1;
    data_wait = 0;
    tick(); tick();
    clear_mem();
    mem[0]   = 32'hC000FFFE;
    mem[255] = 32'h40100001;
    rst = 1'b0;
    k = 0;
    while (!(mem_re && mem_addr == 30'h3FFFFFFF) && k < 20) begin tick(); k++; end
    check("wrap_top_fetch", 64'(mem_re && mem_addr == 30'h3FFFFFFF), 64'(1));
    tick();
    k = 0;
    while (!(mem_re && mem_addr == 30'h0) && k < 6) begin tick(); k++; end
    check("wrap_zero_fetch", 64'(mem_re && mem_addr == 30'h0), 64'(1));
    check("wrap_zero_pc", 64'(dbg_pc), 64'(0));

    // Reset while a store is stalled in MEM
    rst = 1'b1;
    tick(); tick();
    clear_mem();
    mem[0] = 32'hA0000030;
    data_wait = 50;
    rst = 1'b0;
    k = 0;
    while (!mem_we && k < 10) begin tick(); k++; end
    tick(); tick();
    check("midmem_we_before", 64'(mem_we), 64'(1));
    rst = 1'b1;
    tick();
    check("midmem_we_after", 64'({mem_we, mem_re}), 64'(0));
    check("midmem_pc", 64'(dbg_pc), 64'(0));
    rst = 1'b0;
    data_wait = 0;
    tick();

    check("re_we_exclusive", 64'(both_cnt), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
